// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and the datapath mux selects.
package rv_ctrl_pkg;

    // Sixteen codes so that every value of the 4-bit register has a name.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_RSVD11   = 4'd11,
        S_RSVD12   = 4'd12,
        S_RSVD13   = 4'd13,
        S_RSVD14   = 4'd14,
        S_RSVD15   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp plus instruction funct fields to an ALU
// operation. Purely combinational.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       opb5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type sets op[5]; addi with funct7b5=1 stays add.
                    3'b000:  alucontrol = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I core: Moore main FSM sequencing the
// shared memory, IR, register file and PC, plus ALU and immediate decode.
module multicycle_controller
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal
);

    state_t     state, state_next;
    logic [1:0] aluop;
    logic       pcupdate, branch;
    logic       memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples values from before the edge.
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = S_FETCH;
        AdrSrc       = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        pcupdate     = 1'b0;
        branch       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        aluop        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                pcupdate    = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                state_next  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    // PC was already advanced in FETCH, so this is a NOP.
                    default: begin
                        illegal_raw = 1'b1;
                        state_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RS1;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: regwrite_raw = 1'b1;
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pcupdate   = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    // Architectural enables are held off for the whole reset cycle.
    assign PCWrite  = ~rst & (pcupdate | (branch & Zero));
    assign MemWrite = ~rst & memwrite_raw;
    assign IRWrite  = ~rst & irwrite_raw;
    assign RegWrite = ~rst & regwrite_raw;
    assign Illegal  = ~rst & illegal_raw;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .opb5       (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle
// by cycle and compares the full control word against hand-computed values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int errors = 0;
    int checks = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    // Control word: pcw adr mw irw rs[2] sa[2] sb[2] ac[3] imm[2] rw ill
    logic [16:0] ctl;
    assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUControl, ImmSrc, RegWrite, Illegal};

    function automatic logic [16:0] cw(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] ac,
                                       input logic [1:0] imm, input logic rw,
                                       input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, ill};
    endfunction

    task automatic check(input string tag, input logic [16:0] got,
                         input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pcw adr mw irw rs sa sb ac imm rw ill)",
                     tag, got, exp);
        end
    endtask

    // Inputs are driven at the falling edge; compare 1 ns later, then move on.
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        check(tag, ctl, exp);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
    endtask

    function automatic logic [16:0] fetch_cw(input logic [1:0] imm);
        return cw(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
    endfunction

    function automatic logic [16:0] decode_cw(input logic [1:0] imm);
        return cw(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
    endfunction

    // Four-cycle ALU instruction; exp_ac is the hand-decoded ALUControl.
    task automatic alu_instr(input string name, input logic [6:0] o,
                             input logic [2:0] f3, input logic f7,
                             input logic [1:0] sb, input logic [2:0] exp_ac);
        set_instr(o, f3, f7, 1'b0);
        cyc({name, " fetch"},  fetch_cw(2'b00));
        cyc({name, " decode"}, decode_cw(2'b00));
        cyc({name, " exec"},   cw(0, 0, 0, 0, 2'b00, 2'b10, sb, exp_ac, 2'b00, 0, 0));
        cyc({name, " aluwb"},  cw(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
    endtask

    initial begin
        rst = 1'b1;
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        cyc("reset gated", cw(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
        rst = 1'b0;

        // lw: 5 cycles
        cyc("lw fetch",   fetch_cw(2'b00));
        cyc("lw decode",  decode_cw(2'b00));
        cyc("lw memadr",  cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
        cyc("lw memread", cw(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
        cyc("lw memwb",   cw(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));

        // sw: 4 cycles
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        cyc("sw fetch",    fetch_cw(2'b01));
        cyc("sw decode",   decode_cw(2'b01));
        cyc("sw memadr",   cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
        cyc("sw memwrite", cw(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));

        alu_instr("sub",  7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);
        alu_instr("add",  7'b0110011, 3'b000, 1'b0, 2'b00, 3'b000);
        alu_instr("addi", 7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000);
        alu_instr("slt",  7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101);
        alu_instr("or",   7'b0110011, 3'b110, 1'b0, 2'b00, 3'b011);
        alu_instr("andi", 7'b0010011, 3'b111, 1'b0, 2'b01, 3'b010);
        alu_instr("xor",  7'b0110011, 3'b100, 1'b0, 2'b00, 3'b000);

        // beq taken, then not taken: 3 cycles each
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        cyc("beqT fetch",  fetch_cw(2'b10));
        cyc("beqT decode", decode_cw(2'b10));
        cyc("beqT beq",    cw(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        cyc("beqN fetch",  fetch_cw(2'b10));
        cyc("beqN decode", decode_cw(2'b10));
        cyc("beqN beq",    cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));

        // jal: 4 cycles
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        cyc("jal fetch",  fetch_cw(2'b11));
        cyc("jal decode", decode_cw(2'b11));
        cyc("jal jal",    cw(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0));
        cyc("jal aluwb",  cw(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1, 0));

        // illegal op: 2 cycles, Illegal only in DECODE
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        cyc("ill fetch",   fetch_cw(2'b00));
        cyc("ill decode",  cw(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1));
        cyc("ill refetch", fetch_cw(2'b00));
        cyc("ill decode2", cw(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1));

        // reset asserted in MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        cyc("swr fetch",  fetch_cw(2'b01));
        cyc("swr decode", decode_cw(2'b01));
        cyc("swr memadr", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
        rst = 1'b1;
        cyc("swr rst memwrite", cw(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
        rst = 1'b0;
        cyc("swr after rst", fetch_cw(2'b01));
        cyc("swr decode2",   decode_cw(2'b01));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
